kernel_unpacker: RTL and testbench

KERNEL_UNPACKER -- requirements
Module: kernel_unpacker

---
 rtl/kernel_unpacker_pkg.sv | 6 +
 rtl/kernel_fifo.sv | 53 +++++
 rtl/kernel_unpacker.sv | 98 +++++++++
 tb/tb_kernel_unpacker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_unpacker_pkg.sv
// kernel_unpacker_pkg: serializer state type and tap constants shared by the kernel unpacker
package kernel_unpacker_pkg;
    typedef enum logic {IDLE, EMIT} state_t;
    localparam int KERNEL_TAPS = 9;
    localparam int TAP_IDX_W = 4;
endpackage

// File: rtl/kernel_fifo.sv
// kernel_fifo: circular buffer of packed kernels with registered full/empty flags
module kernel_fifo #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic full_q, empty_q, do_push, do_pop;
    // a push into a full buffer is accepted only when the head leaves in the same cycle
    always_comb begin
        do_pop = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            full_q <= cnt_d == CW'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end
    assign dout = mem[rd_q];
    assign full = full_q;
    assign empty = empty_q;
    assign empty_next = cnt_d == '0;
endmodule

// File: rtl/kernel_unpacker.sv
// kernel_unpacker: captures packed 3x3 kernels on we_w rising edges and streams them out one tap at a time
module kernel_unpacker
    import kernel_unpacker_pkg::*;
#(
    parameter int SIZE_1 = 8,
    parameter int SIZE_9 = 72,
    parameter int SIZE_address_wei = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_w,
    input  logic [SIZE_address_wei-1:0] addrw,
    input  logic [SIZE_9-1:0]           dw,
    input  logic                        flush,
    output logic signed [SIZE_1-1:0]    tap,
    output logic [TAP_IDX_W-1:0]        tap_idx,
    output logic [SIZE_address_wei-1:0] tap_addr,
    output logic                        tap_valid,
    input  logic                        tap_ready,
    output logic                        tap_last,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic                        busy
);
    localparam int FW = SIZE_address_wei + SIZE_9;
    localparam logic [TAP_IDX_W-1:0] LAST_IDX = TAP_IDX_W'(KERNEL_TAPS - 1);
    state_t state_q, state_d;
    logic we_q;
    logic [SIZE_9-1:0] word_q, word_d, shifted;
    logic [SIZE_address_wei-1:0] addr_q, addr_d;
    logic [TAP_IDX_W-1:0] idx_q, idx_d;
    logic signed [SIZE_1-1:0] tap_q, tap_d;
    logic valid_q, last_q, ovf_q, ovf_d, busy_q;
    logic cap, xfer, pop, f_full, f_empty, f_empty_next;
    logic [FW-1:0] f_dout;

    kernel_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (flush),
        .push       (cap),
        .pop        (pop),
        .din        ({addrw, dw}),
        .dout       (f_dout),
        .full       (f_full),
        .empty      (f_empty),
        .empty_next (f_empty_next)
    );

    // the next kernel is loaded while the last tap of the current one leaves, so there is no bubble
    always_comb begin
        cap = we_w && !we_q;
        xfer = (state_q == EMIT) && tap_ready;
        pop = !f_empty && ((state_q == IDLE) || (xfer && idx_q == LAST_IDX));
        ovf_d = ovf_q || (cap && f_full && !pop);
        state_d = pop ? EMIT : (xfer && idx_q == LAST_IDX) ? IDLE : state_q;
        idx_d = pop ? '0 : (xfer && idx_q != LAST_IDX) ? idx_q + TAP_IDX_W'(1) : idx_q;
        {addr_d, word_d} = pop ? f_dout : {addr_q, word_q};
        shifted = word_d << (SIZE_1 * int'(idx_d));
        tap_d = $signed(shifted[SIZE_9-1 -: SIZE_1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= IDLE;
            we_q <= 1'b0;
            word_q <= '0;
            addr_q <= '0;
            idx_q <= '0;
            tap_q <= '0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            ovf_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q <= we_w;
            word_q <= word_d;
            addr_q <= addr_d;
            idx_q <= idx_d;
            tap_q <= tap_d;
            valid_q <= state_d == EMIT;
            last_q <= (state_d == EMIT) && (idx_d == LAST_IDX);
            ovf_q <= ovf_d;
            busy_q <= (state_d == EMIT) || !f_empty_next;
        end
    end

    assign tap = tap_q;
    assign tap_idx = idx_q;
    assign tap_addr = addr_q;
    assign tap_valid = valid_q;
    assign tap_last = last_q;
    assign fifo_full = f_full;
    assign overflow = ovf_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_kernel_unpacker.sv
// tb_kernel_unpacker: directed and random checks of kernel_unpacker against a queue-based kernel model
module tb_kernel_unpacker;
    localparam int S1 = 8;
    localparam int S9 = 72;
    localparam int AW = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic we_w = 1'b0;
    logic flush = 1'b0;
    logic tap_ready = 1'b0;
    logic [AW-1:0] addrw = '0;
    logic [S9-1:0] dw = '0;
    logic signed [S1-1:0] tap;
    logic [3:0] tap_idx;
    logic [AW-1:0] tap_addr;
    logic tap_valid, tap_last, fifo_full, overflow, busy;

    int total = 0;
    int bad = 0;
    int xfers = 0;
    int lasts = 0;
    int addr_seen[$];
    logic [AW+S9-1:0] m_q[$];
    logic [AW+S9-1:0] m_cur = '0;
    bit m_valid = 1'b0;
    bit m_ovf = 1'b0;
    bit m_wep = 1'b0;
    int m_idx = 0;

    always #5 clk = ~clk;

    kernel_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_w      (we_w),
        .addrw     (addrw),
        .dw        (dw),
        .flush     (flush),
        .tap       (tap),
        .tap_idx   (tap_idx),
        .tap_addr  (tap_addr),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    function automatic logic [7:0] elem(input logic [AW+S9-1:0] k, input int i);
        return 8'(k[S9-1:0] >> (8 * (8 - i)));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock of the kernel-level model: a tap leaves, the head refills the output, then a capture queues
    task automatic model_update();
        bit xfer, pop, cap, full;
        if (!rst_n || flush) begin
            m_q.delete();
            m_valid = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
            m_wep = 1'b0;
            return;
        end
        xfer = m_valid && tap_ready;
        pop = (m_q.size() > 0) && (!m_valid || (xfer && m_idx == 8));
        cap = we_w && !m_wep;
        full = m_q.size() == DEPTH;
        if (xfer) begin
            if (m_idx < 8) m_idx++;
            else m_valid = 1'b0;
        end
        if (pop) begin
            m_cur = m_q.pop_front();
            m_idx = 0;
            m_valid = 1'b1;
        end
        if (cap) begin
            if (!full || pop) m_q.push_back({addrw, dw});
            else m_ovf = 1'b1;
        end
        m_wep = we_w;
    endtask

    task automatic check();
        chk("tap_valid", tap_valid, m_valid);
        chk("fifo_full", fifo_full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_valid || m_q.size() > 0);
        if (m_valid) begin
            chk("tap", $unsigned(tap), elem(m_cur, m_idx));
            chk("tap_idx", tap_idx, m_idx);
            chk("tap_addr", tap_addr, m_cur[AW+S9-1:S9]);
            chk("tap_last", tap_last, m_idx == 8);
        end
    endtask

    task automatic tick();
        if (tap_valid && tap_ready) begin
            xfers++;
            if (tap_last) lasts++;
            if (tap_idx == 0) addr_seen.push_back(int'(tap_addr));
        end
        model_update();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic pulse(input int a, input logic [S9-1:0] d);
        addrw = AW'(a);
        dw = d;
        we_w = 1'b1;
        tick();
        we_w = 1'b0;
    endtask

    function automatic logic [S9-1:0] rnd_word();
        return S9'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        repeat (2) tick();
        chk("rst_tap", $unsigned(tap), 0);
        chk("rst_idx", tap_idx, 0);
        chk("rst_addr", tap_addr, 0);
        chk("rst_last", tap_last, 0);
        rst_n = 1'b1;
        tap_ready = 1'b1;

        xfers = 0;
        lasts = 0;
        pulse(5, 72'h010203040506070809);
        chk("lat_n1", tap_valid, 0);
        tick();
        chk("lat_n2", tap_valid, 1);
        chk("first_tap", $unsigned(tap), 1);
        repeat (10) tick();
        chk("single_xfers", xfers, 9);
        chk("single_lasts", lasts, 1);
        chk("single_busy", busy, 0);

        xfers = 0;
        addrw = 10'd6;
        dw = rnd_word();
        we_w = 1'b1;
        tick();
        tick();
        we_w = 1'b0;
        repeat (14) tick();
        chk("held_xfers", xfers, 9);
        chk("held_busy", busy, 0);

        xfers = 0;
        pulse(9, rnd_word());
        for (int i = 0; i < 40; i++) begin
            tap_ready = (i % 2) == 0;
            tick();
        end
        chk("bp_xfers", xfers, 9);

        tap_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(i, rnd_word());
            tick();
        end
        chk("full_flag", fifo_full, 1);
        chk("full_ovf", overflow, 1);
        xfers = 0;
        addr_seen.delete();
        tap_ready = 1'b1;
        repeat (45) tick();
        chk("full_xfers", xfers, 45);
        chk("full_order_n", addr_seen.size(), 5);
        foreach (addr_seen[i]) chk("full_order", addr_seen[i], i);
        chk("full_idle", tap_valid, 0);

        pulse(7, {8'h80, 64'({$urandom(), $urandom()})});
        tick();
        chk("neg_tap", int'(tap) == -128, 1);
        repeat (12) tick();

        for (int pass = 0; pass < 2; pass++) begin
            tap_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                pulse(20 + i, rnd_word());
                tick();
            end
            tap_ready = 1'b1;
            for (int i = 0; i < 20 && !(tap_valid && tap_idx == 4); i++) tick();
            chk("mid_reached", tap_valid && tap_idx == 4, 1);
            if (pass == 0) begin
                flush = 1'b1;
                we_w = 1'b1;
            end else rst_n = 1'b0;
            tick();
            flush = 1'b0;
            rst_n = 1'b1;
            we_w = 1'b0;
            chk("abort_valid", tap_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ovf", overflow, 0);
            pulse(11, rnd_word());
            tick();
            chk("restart_valid", tap_valid, 1);
            chk("restart_idx", tap_idx, 0);
            chk("restart_addr", tap_addr, 11);
            repeat (12) tick();
        end

        for (int i = 0; i < 3000; i++) begin
            we_w = $urandom_range(0, 2) == 0;
            tap_ready = $urandom_range(0, 7) < (((i / 400) % 2) == 1 ? 1 : 6);
            addrw = AW'($urandom());
            dw = rnd_word();
            flush = $urandom_range(0, 199) == 0;
            rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        flush = 1'b0;
        rst_n = 1'b1;
        we_w = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
